// File: rtl/instr_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : instr_ctrl_fsm
// Description : Moore control unit for the ProjectB datapath. Runs a
//               fetch / decode / execute loop. It drives the PC clear and
//               increment, the instruction-register load, and the
//               data-memory, register-file and ALU controls that are
//               decoded from the latched 16-bit instruction.
//
// Ports       : clk        - system clock, rising edge
//               rst_n      - synchronous active-low reset
//               ir         - instruction held in the instruction register
//               pc_clr     - clear program counter (INIT)
//               pc_up      - increment program counter (FETCH)
//               ir_ld      - instruction-register load enable (FETCH)
//               d_addr     - data-memory address
//               d_wr       - data-memory write enable
//               rf_s       - RF write-data select (1 = memory, 0 = ALU)
//               rf_w_addr  - RF write address
//               rf_w_en    - RF write enable
//               rf_ra_addr - RF read port A address
//               rf_rb_addr - RF read port B address
//               alu_s0     - ALU op (000 pass A, 001 add, 010 sub)
//               halted     - high while in HALT
//
// Options     : ILLEGAL_TRAP_EN - when defined, opcodes 0110..1111 trap
//               to HALT. When undefined they execute as NOOP.
//
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ctrl_fsm #(
    parameter int DADDR_W = 8,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        ir,
    output logic               pc_clr,
    output logic               pc_up,
    output logic               ir_ld,
    output logic [DADDR_W-1:0] d_addr,
    output logic               d_wr,
    output logic               rf_s,
    output logic [RADDR_W-1:0] rf_w_addr,
    output logic               rf_w_en,
    output logic [RADDR_W-1:0] rf_ra_addr,
    output logic [RADDR_W-1:0] rf_rb_addr,
    output logic [2:0]         alu_s0,
    output logic               halted
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] c_ST_INIT   = 4'd0;
    localparam logic [3:0] c_ST_FETCH  = 4'd1;
    localparam logic [3:0] c_ST_DECODE = 4'd2;
    localparam logic [3:0] c_ST_LOAD_A = 4'd3;
    localparam logic [3:0] c_ST_LOAD_B = 4'd4;
    localparam logic [3:0] c_ST_STORE  = 4'd5;
    localparam logic [3:0] c_ST_ADD    = 4'd6;
    localparam logic [3:0] c_ST_SUB    = 4'd7;
    localparam logic [3:0] c_ST_HALT   = 4'd8;

    // Opcodes (ir[15:12])
    localparam logic [3:0] c_OP_NOOP  = 4'b0000;
    localparam logic [3:0] c_OP_STORE = 4'b0001;
    localparam logic [3:0] c_OP_LOAD  = 4'b0010;
    localparam logic [3:0] c_OP_ADD   = 4'b0011;
    localparam logic [3:0] c_OP_SUB   = 4'b0100;
    localparam logic [3:0] c_OP_HALT  = 4'b0101;

    // ALU operation codes
    localparam logic [2:0] c_ALU_PASS = 3'b000;
    localparam logic [2:0] c_ALU_ADD  = 3'b001;
    localparam logic [2:0] c_ALU_SUB  = 3'b010;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] w_opcode;

    assign w_opcode = ir[15:12];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = c_ST_INIT;
        case (r_state)
            c_ST_INIT:   w_next_state = c_ST_FETCH;
            c_ST_FETCH:  w_next_state = c_ST_DECODE;
            c_ST_DECODE: begin
                case (w_opcode)
                    c_OP_NOOP:  w_next_state = c_ST_FETCH;
                    c_OP_STORE: w_next_state = c_ST_STORE;
                    c_OP_LOAD:  w_next_state = c_ST_LOAD_A;
                    c_OP_ADD:   w_next_state = c_ST_ADD;
                    c_OP_SUB:   w_next_state = c_ST_SUB;
                    c_OP_HALT:  w_next_state = c_ST_HALT;
`ifdef ILLEGAL_TRAP_EN
                    default:    w_next_state = c_ST_HALT;
`else
                    default:    w_next_state = c_ST_FETCH;
`endif
                endcase
            end
            // The synchronous RAM needs one cycle to present its read data,
            // so the RF write happens in the second load state.
            c_ST_LOAD_A: w_next_state = c_ST_LOAD_B;
            c_ST_LOAD_B: w_next_state = c_ST_FETCH;
            c_ST_STORE:  w_next_state = c_ST_FETCH;
            c_ST_ADD:    w_next_state = c_ST_FETCH;
            c_ST_SUB:    w_next_state = c_ST_FETCH;
            c_ST_HALT:   w_next_state = c_ST_HALT;
            // An unused encoding recovers through INIT.
            default:     w_next_state = c_ST_INIT;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: current state plus the latched instruction)
    // ------------------------------------------------------------------
    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = c_ALU_PASS;
        halted     = 1'b0;
        case (r_state)
            c_ST_INIT: begin
                pc_clr = 1'b1;
            end
            // IR captures and PC advances together on the FETCH->DECODE edge.
            c_ST_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            c_ST_LOAD_A: begin
                d_addr = DADDR_W'(ir[11:4]);
                rf_s   = 1'b1;
            end
            c_ST_LOAD_B: begin
                d_addr    = DADDR_W'(ir[11:4]);
                rf_s      = 1'b1;
                rf_w_addr = RADDR_W'(ir[3:0]);
                rf_w_en   = 1'b1;
            end
            // Store data goes through the ALU in pass-A mode.
            c_ST_STORE: begin
                d_addr     = DADDR_W'(ir[7:0]);
                rf_ra_addr = RADDR_W'(ir[11:8]);
                alu_s0     = c_ALU_PASS;
                d_wr       = 1'b1;
            end
            c_ST_ADD: begin
                rf_ra_addr = RADDR_W'(ir[11:8]);
                rf_rb_addr = RADDR_W'(ir[7:4]);
                rf_w_addr  = RADDR_W'(ir[3:0]);
                alu_s0     = c_ALU_ADD;
                rf_w_en    = 1'b1;
            end
            c_ST_SUB: begin
                rf_ra_addr = RADDR_W'(ir[11:8]);
                rf_rb_addr = RADDR_W'(ir[7:4]);
                rf_w_addr  = RADDR_W'(ir[3:0]);
                alu_s0     = c_ALU_SUB;
                rf_w_en    = 1'b1;
            end
            c_ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                // DECODE and unused encodings: all outputs stay 0
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/instr_ctrl_fsm.md
Name: instr_ctrl_fsm

Overview:
- Moore control unit for the ProjectB datapath.
- Drives PC clear/increment and the instruction-register load.
- Decodes the latched 16-bit instruction and sequences data-memory, register-file and ALU controls through a fetch/decode/execute loop.
- Sits between the instruction register (ir input) and the datapath control pins.

Parameters:
- DADDR_W, 8, data-memory address width (ir[11:4] / ir[7:0] fields)
- RADDR_W, 4, register-file address width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset; sampled on the rising edge of clk
- ir  input  16  instruction held in the instruction register
- pc_clr  output  1  clear program counter
- pc_up  output  1  increment program counter
- ir_ld  output  1  load enable to the instruction register
- d_addr  output  DADDR_W  data-memory address
- d_wr  output  1  data-memory write enable
- rf_s  output  1  RF write-data select: 1 = memory, 0 = ALU
- rf_w_addr  output  RADDR_W  RF write address
- rf_w_en  output  1  RF write enable
- rf_ra_addr  output  RADDR_W  RF read port A address
- rf_rb_addr  output  RADDR_W  RF read port B address
- alu_s0  output  3  ALU op: 000 pass A, 001 add, 010 sub
- halted  output  1  high while in HALT

Behaviour:
- Opcode = ir[15:12].
- Decoding: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB, 0101 HALT; all others are treated as NOOP.
- Field mapping:
  - LOAD: d_addr = ir[11:4], rf_w_addr = ir[3:0].
  - STORE: rf_ra_addr = ir[11:8], d_addr = ir[7:0].
  - ADD/SUB: ra = ir[11:8], rb = ir[7:4], rf_w_addr = ir[3:0].
- States: INIT, FETCH, DECODE, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Transitions:
  - INIT -> FETCH -> DECODE.
  - DECODE -> LOAD_A | STORE | ADD | SUB | HALT | FETCH (NOOP/illegal).
  - LOAD_A -> LOAD_B -> FETCH.
  - STORE/ADD/SUB -> FETCH.
  - HALT -> HALT.
- Latency: NOOP 2 cycles; STORE/ADD/SUB 3; LOAD 4 (synchronous RAM needs an extra read cycle).
- Outputs are decoded from the current state and ir only, with no registered outputs. Every output is 0 unless listed below:
  - INIT: pc_clr = 1.
  - FETCH: ir_ld = 1, pc_up = 1. The IR captures on the FETCH->DECODE edge; PC advances on the same edge.
  - DECODE: all 0.
  - LOAD_A: d_addr driven, rf_s = 1.
  - LOAD_B: d_addr driven, rf_s = 1, rf_w_addr driven, rf_w_en = 1.
  - STORE: d_addr driven, rf_ra_addr driven, alu_s0 = 000, d_wr = 1.
  - ADD: ra/rb/rf_w_addr driven, alu_s0 = 001, rf_w_en = 1, rf_s = 0.
  - SUB: as ADD with alu_s0 = 010.
  - HALT: halted = 1.
- Reset: rst_n low at a rising edge forces INIT from any state, including mid-LOAD or HALT. During INIT: pc_clr = 1 and every other output = 0 (address buses = 0).
- HALT exits only via reset.
- ir is sampled only in DECODE and execute states. Changes to ir in other states have no effect.
- Write enables (d_wr, rf_w_en) are high for exactly one cycle per instruction. They are never asserted in FETCH, DECODE or INIT.
- Address buses read 0 in states that do not use them.
- The next-state case must be full. An unreachable encoding goes to INIT.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: opcodes 0110–1111 in DECODE go to HALT, and halted = 1.
- Not defined: those opcodes behave as NOOP (DECODE -> FETCH).

Test Plan:
- Reset: hold rst_n = 0 for 2 clocks -> pc_clr = 1, all other outputs 0. Release -> next cycle FETCH with ir_ld = 1, pc_up = 1.
- LOAD ir = 16'h2AB3 -> LOAD_A: d_addr = 8'hAB, rf_s = 1. LOAD_B: rf_w_addr = 3, rf_w_en = 1 for one cycle. Then FETCH; 4 cycles total.
- STORE ir = 16'h1512 -> d_addr = 8'h12, rf_ra_addr = 5, d_wr = 1 for exactly one cycle, alu_s0 = 000.
- ADD ir = 16'h3127, then SUB ir = 16'h4127 -> ra = 1, rb = 2, rf_w_addr = 7, rf_w_en = 1, alu_s0 = 001 then 010. Each instruction takes 3 cycles.
- HALT ir = 16'h5000 -> halted stays 1 for 10+ cycles with no enables asserted. rst_n = 0 -> INIT. Also assert rst_n = 0 during LOAD_A -> INIT next edge, rf_w_en never asserts.
- Opcode 16'hF000 -> without ILLEGAL_TRAP_EN: DECODE -> FETCH. With ILLEGAL_TRAP_EN: halted = 1.
